// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM-stage data-memory access unit.
//   - state_t          : access FSM states (IDLE, ACCESS, COMPLETE)
//   - SZ_*             : access size encodings carried in mem_control[3:2]
//   - MC_*             : bit positions inside the 4-bit MEM control word
//   - is_misaligned()  : natural-alignment test used by the optional
//                        alignment check (macro MEM_ALIGN_CHECK_EN)
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;  // behaves as a word access

  localparam int MC_EN      = 0;
  localparam int MC_WRITE   = 1;
  localparam int MC_SIZE_LO = 2;
  localparam int MC_SIZE_HI = 3;

  // Word (and reserved) accesses need addr[1:0]==0, halfwords need addr[0]==0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      default: bad = (lane != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for one data-bus access.
// Ports:
//   size       in  2   access size (SZ_WORD / SZ_BYTE / SZ_HALF / SZ_RSVD)
//   lane       in  2   byte address bits [1:0]
//   store_data in  32  raw store data (byte in [7:0], halfword in [15:0])
//   rdata      in  32  read word from the bus
//   be         out 4   byte enables for the addressed lane(s)
//   wdata      out 32  store data replicated across all lanes
//   load_ext   out 32  addressed lane(s) of rdata, zero-extended
// Word accesses ignore lane, halfword accesses ignore lane[0] (force-align).
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_ext
);

  always_comb begin
    be       = 4'b1111;
    wdata    = store_data;
    load_ext = rdata;
    case (size)
      SZ_BYTE: begin
        be       = 4'b0001 << lane;
        wdata    = {4{store_data[7:0]}};
        load_ext = {24'h0, rdata[{lane, 3'b000} +: 8]};
      end
      SZ_HALF: begin
        be       = 4'b0011 << {lane[1], 1'b0};
        wdata    = {2{store_data[15:0]}};
        load_ext = {16'h0, rdata[{lane[1], 4'b0000} +: 16]};
      end
      default: begin
        be       = 4'b1111;
        wdata    = store_data;
        load_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
// Takes the MEM control word, address and store data from EX/MEM, runs one
// request/acknowledge transaction on the data bus, stalls the pipeline while
// it is in flight and presents zero-extended load data to MEM/WB.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   mem_control_in    [0] mem_en, [1] mem_write, [3:2] size
//   addr_in           byte address;  store_data_in  store data
//   bus_req/we/addr/wdata/be   data-bus request (valid only in ACCESS)
//   bus_ack/bus_rdata          one-cycle completion and read word
//   load_data         aligned load result, held until the next completion
//   mem_stall         hold upstream pipeline stages
//   mem_done          one-cycle completion pulse
//   bus_error         pulse with mem_done when the access timed out
//   align_fault       pulse with mem_done on a misaligned access
// Build option: define MEM_ALIGN_CHECK_EN to reject misaligned word/halfword
// accesses without a bus request; otherwise they are force-aligned and
// align_fault stays 0.
module mem_access_unit
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        mem_control_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       store_data_in,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic [31:0]       load_data,
  output logic              mem_stall,
  output logic              mem_done,
  output logic              bus_error,
  output logic              align_fault
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state_reg, state_next;

  // Request registers: the bus sees only these, so EX/MEM may change freely
  // once the access has been accepted.
  logic [ADDR_W-1:0] word_addr_reg;
  logic              we_reg;
  logic [1:0]        size_reg;
  logic [1:0]        lane_reg;
  logic [31:0]       sdata_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              err_reg;
  logic [31:0]       load_data_reg;

  logic        mem_en;
  logic        reject;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;

  assign mem_en = mem_control_in[MC_EN];

`ifdef MEM_ALIGN_CHECK_EN
  logic fault_reg;
  assign reject = is_misaligned(mem_control_in[MC_SIZE_HI:MC_SIZE_LO], addr_in[1:0]);
`else
  assign reject = 1'b0;
`endif

  // Steering works from the registered request, so be/wdata are stable for
  // the whole ACCESS phase.
  mem_lane_align u_lane_align (
    .size       (size_reg),
    .lane       (lane_reg),
    .store_data (sdata_reg),
    .rdata      (bus_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_ext   (lane_load)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; an ack on the last counted cycle still wins.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (mem_en) state_next = reject ? COMPLETE : ACCESS;
      end
      ACCESS: begin
        if (bus_ack || (cnt_reg == CNT_LAST)) state_next = COMPLETE;
      end
      COMPLETE: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Request capture, timeout counter and load result
  always_ff @(posedge clk) begin
    if (reset) begin
      word_addr_reg <= '0;
      we_reg        <= 1'b0;
      size_reg      <= SZ_WORD;
      lane_reg      <= 2'b00;
      sdata_reg     <= 32'h0;
      cnt_reg       <= '0;
      err_reg       <= 1'b0;
      load_data_reg <= 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
      fault_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (mem_en) begin
            word_addr_reg <= {addr_in[ADDR_W-1:2], 2'b00};
            we_reg        <= mem_control_in[MC_WRITE];
            size_reg      <= mem_control_in[MC_SIZE_HI:MC_SIZE_LO];
            lane_reg      <= addr_in[1:0];
            sdata_reg     <= store_data_in;
            cnt_reg       <= '0;
            err_reg       <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            fault_reg     <= reject;
`endif
          end
        end
        ACCESS: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (bus_ack) begin
            if (!we_reg) load_data_reg <= lane_load;
          end else if (cnt_reg == CNT_LAST) begin
            err_reg       <= 1'b1;
            load_data_reg <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs; bus fields read as 0 outside ACCESS.
  always_comb begin
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = '0;
    bus_wdata   = 32'h0;
    bus_be      = 4'b0000;
    mem_stall   = 1'b0;
    mem_done    = 1'b0;
    bus_error   = 1'b0;
    align_fault = 1'b0;
    case (state_reg)
      IDLE: mem_stall = mem_en;
      ACCESS: begin
        bus_req   = 1'b1;
        bus_we    = we_reg;
        bus_addr  = word_addr_reg;
        bus_wdata = lane_wdata;
        bus_be    = lane_be;
        mem_stall = 1'b1;
      end
      COMPLETE: begin
        mem_done  = 1'b1;
        bus_error = err_reg;
`ifdef MEM_ALIGN_CHECK_EN
        align_fault = fault_reg;
`endif
      end
      default: ;
    endcase
  end

  assign load_data = load_data_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit.
// Expected completion results go into a queue when an access is issued and
// are compared by a monitor whenever mem_done pulses.
module tb_mem_access_unit;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              reset;
  logic [3:0]        mem_control_in;
  logic [ADDR_W-1:0] addr_in;
  logic [31:0]       store_data_in;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_ack;
  logic [31:0]       bus_rdata;
  logic [31:0]       load_data;
  logic              mem_stall;
  logic              mem_done;
  logic              bus_error;
  logic              align_fault;

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_control_in (mem_control_in),
    .addr_in        (addr_in),
    .store_data_in  (store_data_in),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_be         (bus_be),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata),
    .load_data      (load_data),
    .mem_stall      (mem_stall),
    .mem_done       (mem_done),
    .bus_error      (bus_error),
    .align_fault    (align_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ld;
    logic        err;
    logic        flt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_load = 32'h0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: one completion per queued expectation.
  always @(negedge clk) begin
    if (mem_done === 1'b1) begin
      check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("sb_load_data", load_data, e.ld);
        check_val("sb_bus_error", 32'(bus_error), 32'(e.err));
        check_val("sb_align_fault", 32'(align_fault), 32'(e.flt));
        $display("completion: load_data=%h bus_error=%0b align_fault=%0b", load_data, bus_error, align_fault);
      end
    end
  end

  // One memory operation. waits: ACCESS cycles before ack (-1 = never ack).
  task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata, input int waits,
                        input bit fault, input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input logic [31:0] e_load, input bit e_err);
    int cyc;
    int stalls;
    bit done;
    int exp_cyc;
    int exp_stalls;
    exp_q.push_back('{ld: e_load, err: e_err, flt: fault});
    @(posedge clk); #1;
    mem_control_in = ctrl;
    addr_in        = addr;
    store_data_in  = sdata;
    cyc = 1; stalls = 0; done = 0;
    @(negedge clk);
    if (mem_stall) stalls++;
    check_val({tag, "_req_detect"}, 32'(bus_req), 32'd0);
    for (int i = 0; i < TIMEOUT + 4 && !done; i++) begin
      @(posedge clk); #1;
      // Request is registered; scramble EX/MEM (with mem_en low) to prove it.
      mem_control_in = {~ctrl[3:1], 1'b0};
      addr_in        = $urandom;
      store_data_in  = $urandom;
      bus_ack        = (i == waits);
      bus_rdata      = (i == waits) ? rdata : $urandom;
      cyc++;
      @(negedge clk);
      if (mem_done) begin
        done = 1;
        check_val({tag, "_req_complete"}, 32'(bus_req), 32'd0);
        check_val({tag, "_stall_complete"}, 32'(mem_stall), 32'd0);
      end else begin
        if (mem_stall) stalls++;
        check_val({tag, "_req"}, 32'(bus_req), 32'd1);
        check_val({tag, "_we"}, 32'(bus_we), 32'(ctrl[1]));
        check_val({tag, "_addr"}, bus_addr, {addr[31:2], 2'b00});
        check_val({tag, "_be"}, 32'(bus_be), 32'(e_be));
        check_val({tag, "_wdata"}, bus_wdata, e_wdata);
      end
    end
    bus_ack = 1'b0;
    check_val({tag, "_done_seen"}, 32'(done), 32'd1);
    if (fault) begin
      exp_cyc = 2; exp_stalls = 1;
    end else if (waits < 0) begin
      exp_cyc = TIMEOUT + 2; exp_stalls = TIMEOUT + 1;
    end else begin
      exp_cyc = waits + 3; exp_stalls = waits + 2;
    end
    check_val({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check_val({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    @(posedge clk); #1;
    @(negedge clk);
    check_val({tag, "_done_pulse"}, 32'(mem_done), 32'd0);
    check_val({tag, "_err_pulse"}, 32'(bus_error), 32'd0);
    $display("op %s: ctrl=%b addr=%h waits=%0d cycles=%0d stalls=%0d load_data=%h",
             tag, ctrl, addr, waits, cyc, stalls, load_data);
    last_load = e_load;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    mem_control_in = 4'h0;
    addr_in        = '0;
    store_data_in  = 32'h0;
    bus_ack        = 1'b0;
    bus_rdata      = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_bus_req", 32'(bus_req), 32'd0);
    check_val("rst_bus_we", 32'(bus_we), 32'd0);
    check_val("rst_bus_addr", bus_addr, 32'h0);
    check_val("rst_bus_wdata", bus_wdata, 32'h0);
    check_val("rst_bus_be", 32'(bus_be), 32'd0);
    check_val("rst_load_data", load_data, 32'h0);
    check_val("rst_stall", 32'(mem_stall), 32'd0);
    check_val("rst_done", 32'(mem_done), 32'd0);
    check_val("rst_bus_error", 32'(bus_error), 32'd0);
    check_val("rst_align_fault", 32'(align_fault), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("idle_stall", 32'(mem_stall), 32'd0);

    run_op("ld_w", 4'b0001, 32'h100, 32'h12345678, 32'hDEADBEEF, 0, 0, 4'b1111, 32'h12345678, 32'hDEADBEEF, 0);
    run_op("st_b", 4'b0111, 32'h203, 32'h000000A5, 32'h0, 1, 0, 4'b1000, 32'hA5A5A5A5, last_load, 0);
    run_op("ld_b", 4'b0101, 32'h201, 32'h0, 32'h11223344, 0, 0, 4'b0010, 32'h0, 32'h00000033, 0);
    run_op("ld_h", 4'b1001, 32'h302, 32'h0, 32'hCAFE1234, 3, 0, 4'b1100, 32'h0, 32'h0000CAFE, 0);
    run_op("st_h", 4'b1011, 32'h300, 32'h9999BEEF, 32'h0, 2, 0, 4'b0011, 32'hBEEFBEEF, last_load, 0);
    run_op("ld_rsvd", 4'b1101, 32'h404, 32'h87654321, 32'h0BADF00D, 0, 0, 4'b1111, 32'h87654321, 32'h0BADF00D, 0);
    run_op("ld_b0", 4'b0101, 32'h500, 32'h0000005A, 32'hFFFFFF80, 1, 0, 4'b0001, 32'h5A5A5A5A, 32'h00000080, 0);
`ifdef MEM_ALIGN_CHECK_EN
    run_op("ld_w_mis", 4'b0001, 32'h101, 32'h0F0F0F0F, 32'h55667788, 99, 1, 4'b1111, 32'h0F0F0F0F, last_load, 0);
    run_op("ld_h_mis", 4'b1001, 32'h303, 32'h00001111, 32'hCAFE1234, 99, 1, 4'b1100, 32'h11111111, last_load, 0);
`else
    run_op("ld_w_mis", 4'b0001, 32'h101, 32'h0F0F0F0F, 32'h55667788, 0, 0, 4'b1111, 32'h0F0F0F0F, 32'h55667788, 0);
    run_op("ld_h_mis", 4'b1001, 32'h303, 32'h00001111, 32'hCAFE1234, 1, 0, 4'b1100, 32'h11111111, 32'h0000CAFE, 0);
`endif
    run_op("ld_ack_last", 4'b0001, 32'h700, 32'h0, 32'h13579BDF, TIMEOUT - 1, 0, 4'b1111, 32'h0, 32'h13579BDF, 0);
    run_op("ld_tmo", 4'b0001, 32'h800, 32'h0, 32'h0, -1, 0, 4'b1111, 32'h0, 32'h0, 1);

    // Stray ack two cycles after the timed-out request dropped.
    @(posedge clk); #1;
    bus_ack   = 1'b1;
    bus_rdata = 32'hAAAA5555;
    @(negedge clk);
    check_val("stray_req", 32'(bus_req), 32'd0);
    check_val("stray_done", 32'(mem_done), 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check_val("stray_done_next", 32'(mem_done), 32'd0);
    check_val("stray_load", load_data, 32'h0);
    $display("stray ack: bus_req=%0b mem_done=%0b load_data=%h", bus_req, mem_done, load_data);

    // Reset during the second ACCESS cycle.
    @(posedge clk); #1;
    mem_control_in = 4'b0001;
    addr_in        = 32'h600;
    @(posedge clk); #1;
    mem_control_in = 4'h0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_val("rmid_req_before", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    reset     = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check_val("rmid_req", 32'(bus_req), 32'd0);
    check_val("rmid_stall", 32'(mem_stall), 32'd0);
    check_val("rmid_done", 32'(mem_done), 32'd0);
    check_val("rmid_be", 32'(bus_be), 32'd0);
    check_val("rmid_addr", bus_addr, 32'h0);
    check_val("rmid_load", load_data, 32'h0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check_val("rmid_late_done", 32'(mem_done), 32'd0);
    check_val("rmid_late_load", load_data, 32'h0);
    $display("reset mid-access: bus_req=%0b mem_stall=%0b load_data=%h", bus_req, mem_stall, load_data);
    last_load = 32'h0;

    run_op("ld_post_rst", 4'b0101, 32'h903, 32'h0, 32'hA1B2C3D4, 2, 0, 4'b1000, 32'h0, 32'h000000A1, 0);

    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit, directly downstream of the EX/MEM control register.
- Consumes the 4-bit MEM control word plus the address and store data from EX/MEM.
- Runs a request/acknowledge transaction on the data bus and aligns store and load data per byte lane.
- Stalls the pipeline until the access completes or times out, then presents zero-extended load data to the MEM/WB register.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYCLES, 16, ACCESS cycles without bus_ack before the access aborts (minimum 2).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- mem_control_in  input  4  [0] mem_en, [1] mem_write, [3:2] size: 00 word, 01 byte, 10 halfword, 11 reserved (treated as word).
- addr_in  input  ADDR_W  byte address from EX/MEM.
- store_data_in  input  32  store data; a byte store uses [7:0], a halfword store uses [15:0].
- bus_req  output  1  request valid.
- bus_we  output  1  write strobe.
- bus_addr  output  ADDR_W  word-aligned address; [1:0] always 0.
- bus_wdata  output  32  lane-replicated store data.
- bus_be  output  4  byte enables.
- bus_ack  input  1  one-cycle completion from memory.
- bus_rdata  input  32  read word, valid when bus_ack=1.
- load_data  output  32  aligned, zero-extended load result; held until the next completion.
- mem_stall  output  1  hold the PC, IF/ID, ID/EX and EX/MEM stages.
- mem_done  output  1  one-cycle pulse in the COMPLETE state.
- bus_error  output  1  one-cycle pulse with mem_done when the access timed out.
- align_fault  output  1  one-cycle pulse with mem_done on a misaligned access (optional feature only).

Behaviour:
- Clock and reset: clk, with reset being synchronous and active-high. Reset forces IDLE.
- Reset values: every output is 0, including load_data; the timeout counter is 0.
- States: IDLE, ACCESS, COMPLETE.
- IDLE:
  - If mem_en=1, capture the request registers (word address, we, be, wdata, lane, size) and go to ACCESS.
  - mem_stall is combinational and equals 1 in this cycle.
  - If mem_en=0, stay in IDLE with mem_stall=0.
- ACCESS:
  - bus_req=1, and bus_we/addr/wdata/be stay stable from the registered copies until the exit edge.
  - mem_stall=1.
  - The counter increments every cycle.
  - On bus_ack=1: for a read, register the extracted load_data; go to COMPLETE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ack: go to COMPLETE with bus_error set and load_data=0.
- COMPLETE:
  - mem_stall=0, mem_done=1, bus_req=0; next state is IDLE.
  - The EX/MEM register advances on this edge.
  - A memory op in the following cycle starts a fresh transaction.
- Latency: a zero-wait-state ack (ack in the first ACCESS cycle) gives 3 cycles from IDLE detect to COMPLETE; each wait state adds 1 cycle.
- Byte enables:
  - word: 1111.
  - byte: 0001 << addr[1:0].
  - halfword: 0011 << {addr[1],1'b0}.
- Store data: byte replicated 4x, halfword replicated 2x, word passed as is.
- Load data: extract the addressed lane and zero-extend to 32 bits. For a write, load_data holds its previous value.
- Misalignment (default build): addr[1:0] is ignored for word accesses and addr[0] is ignored for halfword accesses, i.e. force-aligned.
- Boundaries:
  - bus_ack outside ACCESS is ignored.
  - bus_ack on the timeout cycle counts as success: ack wins and bus_error=0.
  - mem_control_in changes during ACCESS are ignored, because the request is registered.
  - Reset mid-ACCESS drops bus_req on the same edge; a late ack after reset is ignored.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - A word access with addr[1:0]!=0, or a halfword access with addr[0]=1, issues no bus request.
  - IDLE goes directly to COMPLETE with align_fault=1 and mem_done=1, and load_data is unchanged.
  - Latency is 2 cycles.
- Undefined: the force-align behaviour above applies and align_fault is tied to 0.

Decomposition:
- Package mem_stage_pkg:
  - state enum (IDLE, ACCESS, COMPLETE);
  - size encodings SZ_WORD, SZ_BYTE, SZ_HALF, SZ_RSVD;
  - control bit index constants MC_EN=0, MC_WRITE=1, MC_SIZE_LO=2, MC_SIZE_HI=3.
- Sub-module mem_lane_align (combinational):
  - inputs: size and addr[1:0];
  - outputs: be, replicated wdata, and the extracted, zero-extended load data.

Test Plan:
- Word load at addr 0x100, ack in the first ACCESS cycle, rdata 0xDEADBEEF -> be=1111, bus_addr=0x100, mem_stall high for 2 cycles, load_data=0xDEADBEEF with mem_done in cycle 3.
- Byte store at addr 0x203, data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5, bus_we=1; byte load at 0x201 with rdata 0x11223344 -> load_data=0x00000033.
- Halfword load at addr 0x302, rdata 0xCAFE1234, ack after 3 wait states -> load_data=0x0000CAFE, stall lasts 5 cycles, outputs stable while waiting.
- No ack for TIMEOUT_CYCLES=16 -> bus_req drops after 16 ACCESS cycles, bus_error=1 and mem_done=1 for one cycle, load_data=0; an ack arriving 2 cycles later is ignored.
- Reset asserted in the 2nd ACCESS cycle -> next cycle bus_req=0, mem_stall=0, all outputs 0; the following ack is ignored; a new load afterwards works normally.
- With MEM_ALIGN_CHECK_EN: word load at 0x101 -> no bus_req, align_fault=1 and mem_done=1 in cycle 2. Without it: same stimulus -> bus_addr=0x100, be=1111.
